// File: rtl/reglk_pkg.sv
// Shared types and default constants for the register-lock write-protection gate.
package reglk_pkg;

    localparam int unsigned DefNumLockWords = 6;
    localparam int unsigned DefRegionShift  = 8;
    localparam int unsigned DefNumRegions   = 192;
    localparam int unsigned DefCntW         = 16;

    typedef enum logic [2:0] {
        StIdle,
        StDecide,
        StFwd,
        StErr,
        StResp
    } state_e;

    typedef logic [31:0] lock_word_t;
    typedef lock_word_t [DefNumLockWords-1:0] reglk_words_t;

    // Region number is the byte just above the in-region offset.
    function automatic logic [7:0] region_idx(logic [31:0] addr, int unsigned shift);
        return 8'(addr >> shift);
    endfunction

endpackage

// File: rtl/reglk_region_decode.sv
// Combinational map from a byte address to its region's lock bit and an in-range flag.
module reglk_region_decode
    import reglk_pkg::*;
#(
    parameter int unsigned NUM_LOCK_WORDS = DefNumLockWords,
    parameter int unsigned REGION_SHIFT   = DefRegionShift,
    parameter int unsigned NUM_REGIONS    = DefNumRegions
) (
    input  logic [31:0]                     addr_i,
    input  logic [NUM_LOCK_WORDS-1:0][31:0] reglk_i,
    output logic                            lock_bit_o,
    output logic                            in_range_o
);

    logic [7:0] idx;

    assign idx        = region_idx(addr_i, REGION_SHIFT);
    assign in_range_o = (32'(idx) < NUM_REGIONS);

    // Word select by compare keeps indices beyond the array from reading X.
    always_comb begin
        lock_bit_o = 1'b0;
        for (int unsigned w = 0; w < NUM_LOCK_WORDS; w++) begin
            if (32'(idx[7:5]) == w) begin
                lock_bit_o = reglk_i[w[2:0]][idx[4:0]];
            end
        end
    end

endmodule

// File: rtl/reglk_access_ctrl.sv
// Write-protection gate between CPU register bus and peripherals, driven by the lock words.
// Optional violation logging (viol_addr_o, viol_ovf_o) enabled by REGLK_VIOLATION_LOG_EN.
module reglk_access_ctrl
    import reglk_pkg::*;
#(
    parameter int unsigned NUM_LOCK_WORDS = DefNumLockWords,
    parameter int unsigned REGION_SHIFT   = DefRegionShift,
    parameter int unsigned NUM_REGIONS    = DefNumRegions,
    parameter int unsigned CNT_W          = DefCntW
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NUM_LOCK_WORDS-1:0][31:0] reglk_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [31:0]                     req_addr_i,
    input  logic [31:0]                     req_wdata_i,
    output logic                            rsp_valid_o,
    output logic                            rsp_err_o,
    output logic [31:0]                     rsp_rdata_o,
    output logic                            dev_valid_o,
    input  logic                            dev_ready_i,
    output logic                            dev_we_o,
    output logic [31:0]                     dev_addr_o,
    output logic [31:0]                     dev_wdata_o,
    input  logic [31:0]                     dev_rdata_i,
    output logic [CNT_W-1:0]                viol_cnt_o,
`ifdef REGLK_VIOLATION_LOG_EN
    output logic [31:0]                     viol_addr_o,
    output logic                            viol_ovf_o,
`endif
    output logic                            irq_o
);

    state_e             state_q;
    logic               ready_q;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               dev_valid_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [31:0]        rdata_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               irq_q;
`ifdef REGLK_VIOLATION_LOG_EN
    logic [31:0]        viol_addr_q;
    logic               viol_ovf_q;
`endif

    logic lock_bit;
    logic in_range;
    logic blocked;

    reglk_region_decode #(
        .NUM_LOCK_WORDS (NUM_LOCK_WORDS),
        .REGION_SHIFT   (REGION_SHIFT),
        .NUM_REGIONS    (NUM_REGIONS)
    ) u_decode (
        .addr_i     (addr_q),
        .reglk_i    (reglk_i),
        .lock_bit_o (lock_bit),
        .in_range_o (in_range)
    );

    assign blocked = we_q & in_range & lock_bit;

    // The lock decision is taken once at the DECIDE edge; the state holds the snapshot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dev_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            irq_q       <= 1'b0;
`ifdef REGLK_VIOLATION_LOG_EN
            viol_addr_q <= '0;
            viol_ovf_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            irq_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q    <= req_we_i;
                        addr_q  <= req_addr_i;
                        wdata_q <= req_wdata_i;
                        ready_q <= 1'b0;
                        state_q <= StDecide;
                    end
                end
                StDecide: begin
                    if (blocked) begin
                        irq_q   <= 1'b1;
                        state_q <= StErr;
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`ifdef REGLK_VIOLATION_LOG_EN
                        viol_addr_q <= addr_q;
                        if (cnt_q == '1) begin
                            viol_ovf_q <= 1'b1;
                        end
`endif
                    end else begin
                        dev_valid_q <= 1'b1;
                        state_q     <= StFwd;
                    end
                end
                StFwd: begin
                    if (dev_ready_i) begin
                        dev_valid_q <= 1'b0;
                        rdata_q     <= we_q ? 32'h0 : dev_rdata_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StErr: begin
                    rdata_q     <= '0;
                    rsp_err_q   <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    ready_q     <= 1'b1;
                    dev_valid_q <= 1'b0;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rdata_q;
    assign dev_valid_o = dev_valid_q;
    assign dev_we_o    = we_q;
    assign dev_addr_o  = addr_q;
    assign dev_wdata_o = wdata_q;
    assign viol_cnt_o  = cnt_q;
    assign irq_o       = irq_q;
`ifdef REGLK_VIOLATION_LOG_EN
    assign viol_addr_o = viol_addr_q;
    assign viol_ovf_o  = viol_ovf_q;
`endif

endmodule

// File: tb/tb_reglk_access_ctrl.sv
// Directed table-driven bench for reglk_access_ctrl, plus reset and saturation sequences.
module tb_reglk_access_ctrl;
    import reglk_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lock_sel;
        int          late_sel;
        int          delay;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    reglk_words_t reglk = '0;
    logic         req_valid = 1'b0;
    logic         req_we = 1'b0;
    logic [31:0]  req_addr = '0;
    logic [31:0]  req_wdata = '0;
    logic         dev_ready = 1'b0;
    logic [31:0]  dev_rdata = '0;

    logic         req_ready, rsp_valid, rsp_err, dev_valid, dev_we, irq;
    logic [31:0]  rsp_rdata, dev_addr, dev_wdata;
    logic [15:0]  viol_cnt;
    logic [2:0]   sat_cnt;
    logic         sat_irq;
    logic         sat_unused_ready, sat_unused_rvalid, sat_unused_rerr, sat_unused_dvalid;
    logic         sat_unused_dwe;
    logic [31:0]  sat_unused_rdata, sat_unused_daddr, sat_unused_dwdata;
`ifdef REGLK_VIOLATION_LOG_EN
    logic [31:0]  viol_addr, sat_unused_vaddr;
    logic         viol_ovf, sat_ovf;
`endif

    int n_cmp = 0;
    int n_fail = 0;
    logic [15:0] cnt_m = '0;
    logic [2:0]  sat_m = '0;
    logic        sat_ovf_m = 1'b0;
    vec_t        vecs[10];

    always #5 clk = ~clk;

    reglk_access_ctrl u_dut (
        .clk_i (clk), .rst_ni (rst_n), .reglk_i (reglk),
        .req_valid_i (req_valid), .req_ready_o (req_ready), .req_we_i (req_we),
        .req_addr_i (req_addr), .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid), .rsp_err_o (rsp_err), .rsp_rdata_o (rsp_rdata),
        .dev_valid_o (dev_valid), .dev_ready_i (dev_ready), .dev_we_o (dev_we),
        .dev_addr_o (dev_addr), .dev_wdata_o (dev_wdata), .dev_rdata_i (dev_rdata),
        .viol_cnt_o (viol_cnt),
`ifdef REGLK_VIOLATION_LOG_EN
        .viol_addr_o (viol_addr), .viol_ovf_o (viol_ovf),
`endif
        .irq_o (irq)
    );

    // Narrow counter instance shares all stimulus so saturation is reachable quickly.
    reglk_access_ctrl #(.CNT_W(3)) u_dut_sat (
        .clk_i (clk), .rst_ni (rst_n), .reglk_i (reglk),
        .req_valid_i (req_valid), .req_ready_o (sat_unused_ready), .req_we_i (req_we),
        .req_addr_i (req_addr), .req_wdata_i (req_wdata),
        .rsp_valid_o (sat_unused_rvalid), .rsp_err_o (sat_unused_rerr),
        .rsp_rdata_o (sat_unused_rdata),
        .dev_valid_o (sat_unused_dvalid), .dev_ready_i (dev_ready), .dev_we_o (sat_unused_dwe),
        .dev_addr_o (sat_unused_daddr), .dev_wdata_o (sat_unused_dwdata),
        .dev_rdata_i (dev_rdata),
        .viol_cnt_o (sat_cnt),
`ifdef REGLK_VIOLATION_LOG_EN
        .viol_addr_o (sat_unused_vaddr), .viol_ovf_o (sat_ovf),
`endif
        .irq_o (sat_irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_lock(input int sel);
        case (sel)
            0: reglk = '0;
            1: begin reglk = '0; reglk[0][1] = 1'b1; end
            2: reglk = '1;
            default: ;
        endcase
    endtask

    task automatic check_counters();
        check("viol_cnt", 32'(viol_cnt), 32'(cnt_m));
        check("sat_cnt", 32'(sat_cnt), 32'(sat_m));
`ifdef REGLK_VIOLATION_LOG_EN
        check("viol_ovf", 32'(viol_ovf), 32'(0));
        check("sat_ovf", 32'(sat_ovf), 32'(sat_ovf_m));
`endif
    endtask

    task automatic run_txn(input vec_t v);
        set_lock(v.lock_sel);
        dev_rdata = v.rdata;
        dev_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        check("ready_c0", 32'(req_ready), 32'(1));
        @(negedge clk);
        req_valid = 1'b0;
        check("ready_c1", 32'(req_ready), 32'(0));
        check("dvalid_c1", 32'(dev_valid), 32'(0));
        @(negedge clk);
        set_lock(v.late_sel);
        if (v.exp_err) begin
            if (cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'd1;
            if (sat_m == 3'd7) sat_ovf_m = 1'b1;
            else sat_m = sat_m + 3'd1;
            check("irq_err", 32'(irq), 32'(1));
            check("sat_irq", 32'(sat_irq), 32'(1));
            check("dvalid_err", 32'(dev_valid), 32'(0));
            check_counters();
`ifdef REGLK_VIOLATION_LOG_EN
            check("viol_addr", viol_addr, v.addr);
`endif
            @(negedge clk);
        end else begin
            for (int k = 0; k <= v.delay; k++) begin
                check("dvalid_fwd", 32'(dev_valid), 32'(1));
                check("daddr", dev_addr, v.addr);
                check("dwe", 32'(dev_we), 32'(v.we));
                check("dwdata", dev_wdata, v.wdata);
                check("ready_fwd", 32'(req_ready), 32'(0));
                check("irq_fwd", 32'(irq), 32'(0));
                if (k == v.delay) dev_ready = 1'b1;
                @(negedge clk);
            end
            dev_ready = 1'b0;
        end
        check("rsp_valid", 32'(rsp_valid), 32'(1));
        check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        check("dvalid_resp", 32'(dev_valid), 32'(0));
        check("irq_resp", 32'(irq), 32'(0));
        check("ready_resp", 32'(req_ready), 32'(0));
        check_counters();
        @(negedge clk);
        check("rsp_valid_drop", 32'(rsp_valid), 32'(0));
        check("ready_back", 32'(req_ready), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t sv;
        //          we    addr           wdata          rdata         lock late dly err  exp_rdata
        vecs[0] = '{1'b1, 32'h0000_0120, 32'hDEAD_BEEF, 32'hAAAA_5555, 0, -1, 0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 32'h0000_0164, 32'h1111_2222, 32'hAAAA_5555, 1, -1, 0, 1'b1, 32'h0};
        vecs[2] = '{1'b0, 32'h0000_0164, 32'h0,         32'h1234_5678, 1, -1, 4, 1'b0, 32'h1234_5678};
        vecs[3] = '{1'b1, 32'h0000_C800, 32'h0BAD_F00D, 32'h5555_AAAA, 2, -1, 1, 1'b0, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_BF00, 32'h0000_0001, 32'h0,         2, -1, 0, 1'b1, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_C000, 32'h0000_0002, 32'h0,         2, -1, 0, 1'b0, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_0264, 32'h0000_0003, 32'h0,         1, -1, 2, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 32'h0000_0164, 32'h0000_0004, 32'h0,         0,  2, 1, 1'b0, 32'h0};
        vecs[8] = '{1'b1, 32'hFFFF_0364, 32'h0000_0005, 32'h0,         2,  0, 0, 1'b1, 32'h0};
        vecs[9] = '{1'b0, 32'h0000_5A00, 32'h0,         32'hCAFE_F00D, 2, -1, 0, 1'b0, 32'hCAFE_F00D};

        repeat (3) @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'(1));
        check("rst_dvalid", 32'(dev_valid), 32'(0));
        check("rst_rvalid", 32'(rsp_valid), 32'(0));
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_daddr", dev_addr, 32'h0);
        check("rst_irq", 32'(irq), 32'(0));
        check_counters();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_txn(vecs[i]);

        // Reset while a read waits in FWD.
        set_lock(0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0300;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_dvalid", 32'(dev_valid), 32'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_dvalid", 32'(dev_valid), 32'(0));
        check("rst_async_ready", 32'(req_ready), 32'(1));
        cnt_m = '0; sat_m = '0; sat_ovf_m = 1'b0;
        check_counters();
        dev_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_no_rsp", 32'(rsp_valid), 32'(0));
        end
        dev_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("post_rst_ready", 32'(req_ready), 32'(1));
            check("post_rst_rsp", 32'(rsp_valid), 32'(0));
            check("post_rst_dvalid", 32'(dev_valid), 32'(0));
        end

        // Drive the narrow counter to all-ones minus one, then three more violations.
        sv = '{1'b1, 32'h0, 32'h0, 32'h0, 2, -1, 0, 1'b1, 32'h0};
        for (int i = 0; i < 9; i++) begin
            sv.addr  = 32'h0000_0100 + 32'(i * 256) + 32'(i);
            sv.wdata = 32'(i);
            run_txn(sv);
        end
        check("sat_final", 32'(sat_cnt), 32'(7));
        check("main_final", 32'(viol_cnt), 32'(9));
`ifdef REGLK_VIOLATION_LOG_EN
        check("sat_ovf_final", 32'(sat_ovf), 32'(1));
        check("viol_addr_final", viol_addr, 32'h0000_0908);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
